mips_mem_bridge: RTL and testbench
==================================

# mips_mem_bridge

Memory-side bridge directly downstream of the multicycle MIPS core: accepts one word request at a time over a valid/ready handshake and decodes its address into instruction ROM, data RAM or an MMIO page. Accesses synchronous block memories with fixed latency, returns read data or an error flag, and hosts the LED/switch/cycle-counter MMIO registers. Sits between the core's memory port and the FPGA block RAMs and board I/O.

## Interface
- IMEM_BASE, 32'h0040_0000, instruction region base, aligned to 4<<IMEM_AW
- IMEM_AW, 10, instruction ROM word-address width
- DMEM_BASE, 32'h1001_0000, data region base, aligned to 4<<DMEM_AW
- DMEM_AW, 10, data RAM word-address width
- MMIO_BASE, 32'hFFFF_0000, MMIO page base, bits [7:0] zero
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept; equals (state == IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data; 0 on writes and errors
- rsp_err  out  1  misaligned, unmapped or illegal-write access; valid with rsp_valid
- imem_addr  out  IMEM_AW  ROM word address (1-cycle synchronous read)
- imem_rdata  in  32  ROM data
- dmem_addr  out  DMEM_AW  RAM word address (1-cycle synchronous read)
- dmem_we  out  1  RAM write strobe
- dmem_wdata  out  32  RAM write data
- dmem_rdata  in  32  RAM data
- led  out  16  LED register
- sw  in  16  board switches, asynchronous

## Operation
- FSM states IDLE → ACCESS → RESP → IDLE; no other transitions except reset.
- IDLE: on req_valid && req_ready, register addr, we, wdata and decoded region; go ACCESS. req_valid without ready is never sampled.
- Decode (registered at accept): IMEM if addr[31:IMEM_AW+2] matches base; DMEM likewise; MMIO if addr[31:8] == MMIO_BASE[31:8]; else UNMAPPED. addr[1:0] != 0 → error regardless of region.
- ACCESS: drive imem_addr/dmem_addr = addr[AW+1:2]; DMEM write asserts dmem_we for exactly this cycle; LED write updates led <= wdata[15:0] at end of this cycle.
- RESP: rsp_valid = 1 for one cycle; rsp_rdata = selected read source; rsp_err as decoded.
- MMIO map: +0x0 LED (RW, read upper 16 bits 0); +0x4 SW (RO, two-flop synchronized); +0x8 CYCLE (RO). Other offsets → error.
- Errors: IMEM write, write to SW/CYCLE, unmapped, misaligned, unused MMIO offset. Error accesses cause no side effect: dmem_we stays 0, led unchanged.
- CYCLE: free-running 32-bit counter, +1 every clock from reset release, wraps 0xFFFF_FFFF → 0; read value is counter at ACCESS cycle.

## Timing
- Accept at edge T; rsp_valid high in cycle T+2; req_ready high again at T+3. Throughput one request per 3 cycles.
- Memory read data sampled from imem_rdata/dmem_rdata during RESP (one cycle after address driven in ACCESS).
- Reset values: req_ready 1 (state IDLE), rsp_valid 0, rsp_rdata 0, rsp_err 0, dmem_we 0, imem_addr 0, dmem_addr 0, dmem_wdata 0, led 0, CYCLE 0, sw synchronizer 0.
- Reset mid-operation: pending request discarded, no rsp_valid issued, no dmem_we, led returns to 0.
- sw changes visible to reads no earlier than 2 cycles after settling.

## Structure
- Shared defines/package: state encoding, region enum (IMEM, DMEM, MMIO, UNMAPPED), MMIO offsets (LED 0x0, SW 0x4, CYCLE 0x8), default base addresses.
- One sub-module: mips_mmio_regs (LED register, sw synchronizer, cycle counter, offset decode, read mux, illegal-offset flag).

## Test plan
- Read 0x0040_0004 with ROM word 1 = 0x2008_0005 → rsp_valid at T+2, rdata 0x2008_0005, err 0, imem_addr 1.
- Write 0xDEAD_BEEF to 0x1001_0010 then read back → dmem_we one cycle at dmem_addr 4; read returns 0xDEAD_BEEF.
- Write 0x0001_A5A5 to 0xFFFF_0000 → led 0xA5A5; read back 0x0000_A5A5; write 0xFFFF_0008 → err 1, counter unaffected.
- Errors: read 0x1001_0002, read 0x0000_0000, write 0x0040_0000 → each err 1, rdata 0, no dmem_we, led unchanged.
- Read CYCLE twice back-to-back → difference exactly 3; force counter 0xFFFF_FFFE, confirm wrap to 0.
- Assert rst in ACCESS of a DMEM write → no dmem_we, no rsp_valid, all outputs at reset values, req_ready 1.

Source files
------------

// File: rtl/mips_mem_bridge_pkg.sv
// Shared types for the MIPS memory bridge: FSM states, address regions,
// MMIO register offsets and default region base addresses.
package mips_mem_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    R_IMEM,
    R_DMEM,
    R_MMIO,
    R_UNMAPPED
  } region_t;

  localparam logic [7:0] MMIO_LED   = 8'h00;
  localparam logic [7:0] MMIO_SW    = 8'h04;
  localparam logic [7:0] MMIO_CYCLE = 8'h08;

  localparam logic [31:0] DEF_IMEM_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_DMEM_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mips_mmio_regs.sv
// MMIO page registers: LED (RW), synchronized switches (RO), cycle counter (RO).
// Ports: word_off/we select the register, wr_en commits an LED write, rdata/err decode.
module mips_mmio_regs
  import mips_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  word_off,
  input  logic        we,
  input  logic        wr_en,
  input  logic [15:0] wdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] rdata,
  output logic        err
);

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] cycle_q;
  logic        hit_led;
  logic        hit_sw;
  logic        hit_cyc;

  assign hit_led = word_off == MMIO_LED[7:2];
  assign hit_sw  = word_off == MMIO_SW[7:2];
  assign hit_cyc = word_off == MMIO_CYCLE[7:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      cycle_q <= '0;
    end else begin
      if (wr_en) led <= wdata;
      sw_meta <= sw;
      sw_sync <= sw_meta;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Only LED is writable; unused offsets always fault.
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    unique case (1'b1)
      hit_led: rdata = {16'h0, led};
      hit_sw: begin
        rdata = {16'h0, sw_sync};
        err   = we;
      end
      hit_cyc: begin
        rdata = cycle_q;
        err   = we;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mem_bridge.sv
// Memory bridge behind the multicycle MIPS core: decodes one request into ROM,
// RAM or MMIO, drives 1-cycle synchronous memories, answers with rdata/err.
module mips_mem_bridge
  import mips_mem_bridge_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE,
  parameter int          DMEM_AW   = 10,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic [15:0]        led,
  input  logic [15:0]        sw
);

  // Word index wide enough for both memories and the MMIO page offset.
  localparam int A_W = max3(IMEM_AW, DMEM_AW, 6);

  state_t       state_q;
  state_t       state_d;
  region_t      region_q;
  region_t      region_d;
  logic         we_q;
  logic         err_q;
  logic         err_d;
  logic [A_W-1:0] idx_q;
  logic [31:0]  wdata_q;
  logic [31:0]  mmio_q;
  logic         accept;
  logic         imem_hit;
  logic         dmem_hit;
  logic         mmio_hit;
  logic         acc_err;
  logic         led_wr;
  logic [31:0]  mmio_rdata;
  logic         mmio_err;

  assign req_ready = state_q == S_IDLE;
  assign accept    = req_valid && req_ready;

  assign imem_hit =
    req_addr[31:IMEM_AW+2] == IMEM_BASE[31:IMEM_AW+2];
  assign dmem_hit =
    req_addr[31:DMEM_AW+2] == DMEM_BASE[31:DMEM_AW+2];
  assign mmio_hit =
    req_addr[31:8] == MMIO_BASE[31:8];

  always_comb begin
    region_d = R_UNMAPPED;
    case (1'b1)
      imem_hit: region_d = R_IMEM;
      dmem_hit: region_d = R_DMEM;
      mmio_hit: region_d = R_MMIO;
      default:  region_d = R_UNMAPPED;
    endcase
  end

  assign err_d = (|req_addr[1:0])
    || (region_d == R_UNMAPPED)
    || (region_d == R_IMEM && req_we);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // MMIO offset faults are only known once the offset is registered,
  // so they are folded into err_q at the end of ACCESS.
  assign acc_err = err_q
    || (region_q == R_MMIO && mmio_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      region_q <= R_UNMAPPED;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      mmio_q   <= '0;
    end else if (accept) begin
      region_q <= region_d;
      we_q     <= req_we;
      err_q    <= err_d;
      idx_q    <= req_addr[A_W+1:2];
      wdata_q  <= req_wdata;
    end else if (state_q == S_ACCESS) begin
      err_q  <= acc_err;
      mmio_q <= mmio_rdata;
    end
  end

  assign imem_addr  = idx_q[IMEM_AW-1:0];
  assign dmem_addr  = idx_q[DMEM_AW-1:0];
  assign dmem_wdata = wdata_q;
  assign dmem_we    = state_q == S_ACCESS
    && region_q == R_DMEM && we_q && !err_q;
  assign led_wr     = state_q == S_ACCESS
    && region_q == R_MMIO && we_q && !acc_err;

  assign rsp_valid = state_q == S_RESP;
  assign rsp_err   = state_q == S_RESP && err_q;

  always_comb begin
    rsp_rdata = '0;
    if (state_q == S_RESP && !err_q && !we_q) begin
      case (region_q)
        R_IMEM:  rsp_rdata = imem_rdata;
        R_DMEM:  rsp_rdata = dmem_rdata;
        R_MMIO:  rsp_rdata = mmio_q;
        default: rsp_rdata = '0;
      endcase
    end
  end

  mips_mmio_regs u_mmio (
    .clk      (clk),
    .rst      (rst),
    .word_off (idx_q[5:0]),
    .we       (we_q),
    .wr_en    (led_wr),
    .wdata    (wdata_q[15:0]),
    .sw       (sw),
    .led      (led),
    .rdata    (mmio_rdata),
    .err      (mmio_err)
  );

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Scoreboard bench for mips_mem_bridge: directed requests push expected
// responses; a negedge monitor pops and compares each rsp_valid strobe.
module tb_mips_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [15:0] led;
  logic [15:0] sw;

  always #5 clk = ~clk;

  mips_mem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .led        (led),
    .sw         (sw)
  );

  logic [31:0] ram [0:1023];
  int wr_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (imem_addr == 10'd1) imem_rdata <= 32'h2008_0005;
    else imem_rdata <= {16'hC0DE, 6'b0, imem_addr};
  end

  always @(posedge clk) begin
    if (dmem_we) begin
      ram[dmem_addr] <= dmem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    dmem_rdata <= ram[dmem_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rdata = '0;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        if (e.chk) check("rsp_rdata", rsp_rdata, e.rdata);
        last_rdata = rsp_rdata;
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input logic chk,
                       input logic push);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'b0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (push) sb.push_back('{er, ee, chk, cyc + 2});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] v1;
    int w0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    sw = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_led", {16'b0, led}, 32'd0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rst_imem_addr", {22'b0, imem_addr}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ROM reads
    issue(1'b0, 32'h0040_0004, 0, 32'h2008_0005, 0, 1, 1);
    check("imem_addr", {22'b0, imem_addr}, 32'd1);
    wait_rsp();
    issue(1'b0, 32'h0040_0008, 0, 32'hC0DE_0002, 0, 1, 1);
    wait_rsp();

    // RAM write then read back
    w0 = wr_cnt;
    issue(1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 0, 0, 1, 1);
    check("dmem_we", {31'b0, dmem_we}, 32'd1);
    check("dmem_addr", {22'b0, dmem_addr}, 32'd4);
    check("dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    wait_rsp();
    check("dmem_we_count", 32'(wr_cnt - w0), 32'd1);
    issue(1'b0, 32'h1001_0010, 0, 32'hDEAD_BEEF, 0, 1, 1);
    wait_rsp();

    // LED write/readback
    issue(1'b1, 32'hFFFF_0000, 32'h0001_A5A5, 0, 0, 1, 1);
    wait_rsp();
    check("led_value", {16'b0, led}, 32'h0000_A5A5);
    issue(1'b0, 32'hFFFF_0000, 0, 32'h0000_A5A5, 0, 1, 1);
    wait_rsp();

    // Error accesses: no side effects
    w0 = wr_cnt;
    issue(1'b1, 32'hFFFF_0008, 32'h1234_5678, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b0, 32'h1001_0002, 0, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b0, 32'h0000_0000, 0, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b1, 32'h0040_0000, 32'h5555_5555, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b1, 32'h1001_0012, 32'h7777_7777, 0, 1, 1, 1);
    check("misalign_no_we", {31'b0, dmem_we}, 32'd0);
    wait_rsp();
    issue(1'b1, 32'hFFFF_0004, 32'h0000_0F0F, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b0, 32'hFFFF_000C, 0, 0, 1, 1, 1);
    wait_rsp();
    issue(1'b1, 32'hFFFF_0002, 32'h0000_1111, 0, 1, 1, 1);
    wait_rsp();
    check("err_no_we", 32'(wr_cnt - w0), 32'd0);
    check("err_led", {16'b0, led}, 32'h0000_A5A5);

    // Switches through the synchronizer
    sw = 16'h1234;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'hFFFF_0004, 0, 32'h0000_1234, 0, 1, 1);
    wait_rsp();

    // Back-to-back CYCLE reads
    issue(1'b0, 32'hFFFF_0008, 0, 0, 0, 0, 1);
    wait_rsp();
    v1 = last_rdata;
    issue(1'b0, 32'hFFFF_0008, 0, 0, 0, 0, 1);
    wait_rsp();
    check("cycle_delta", last_rdata - v1, 32'd3);

    // Counter wrap
    while (!req_ready) @(negedge clk);
    dut.u_mmio.cycle_q = 32'hFFFF_FFFE;
    @(negedge clk);
    issue(1'b0, 32'hFFFF_0008, 0, 32'h0000_0000, 0, 1, 1);
    wait_rsp();
    issue(1'b0, 32'hFFFF_0008, 0, 32'h0000_0003, 0, 1, 1);
    wait_rsp();

    // Reset during the ACCESS cycle of a RAM write
    issue(1'b1, 32'h1001_0014, 32'h1111_2222, 0, 0, 1, 1);
    wait_rsp();
    w0 = wr_cnt;
    issue(1'b1, 32'h1001_0014, 32'hCAFE_F00D, 0, 0, 1, 0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_err", {31'b0, rsp_err}, 32'd0);
    check("mid_rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("mid_rst_dmem_addr", {22'b0, dmem_addr}, 32'd0);
    check("mid_rst_dmem_wdata", dmem_wdata, 32'd0);
    check("mid_rst_imem_addr", {22'b0, imem_addr}, 32'd0);
    check("mid_rst_led", {16'b0, led}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    issue(1'b0, 32'h1001_0014, 0, 32'h1111_2222, 0, 1, 1);
    wait_rsp();
    issue(1'b0, 32'hFFFF_0000, 0, 32'h0000_0000, 0, 1, 1);
    wait_rsp();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
